// File: rtl/mips_div_pkg.sv
// mips_div_pkg: shared state type and sizing constants for the iterative divider
package mips_div_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int ITER_BITS = $clog2(WIDTH_DEF + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
endpackage

// File: rtl/mips_divider_if.sv
// mips_divider_if: request/result bundle between a divide requester and the divider
interface mips_divider_if #(parameter int WIDTH = 32);
  logic start;
  logic is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic busy;
  logic done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic div_by_zero;
  modport master (output start, is_signed, dividend, divisor,
                  input busy, done, quotient, remainder, div_by_zero);
  modport slave (input start, is_signed, dividend, divisor,
                 output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/div_step.sv
// div_step: one restoring-division iteration (shift, trial subtract, select)
module div_step #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] dvsr,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic neg;
  assign shifted = {rem_in, quo_in[WIDTH-1]};
  assign diff = shifted - {1'b0, dvsr};
  assign neg = diff[WIDTH];
  assign rem_out = neg ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_out = {quo_in[WIDTH-2:0], ~neg};
endmodule

// File: rtl/mips_divider.sv
// mips_divider: fixed-latency signed/unsigned restoring divider (DIV/DIVU)
module mips_divider
  import mips_div_pkg::*;
#(parameter int WIDTH = WIDTH_DEF) (
  input logic clk,
  input logic rst_n,
  mips_divider_if.slave bus
);
  state_t state, state_nx;
  logic [ITER_BITS-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dvsr, rem_nx, quo_nx;
  logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;
  logic [WIDTH-1:0] q_out, r_out;
  logic neg_q, neg_r, dz, dz_out;
  logic accept;
  assign accept = state == IDLE && bus.start;
  assign a_mag = (bus.is_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
  assign b_mag = (bus.is_signed && bus.divisor[WIDTH-1]) ? -bus.divisor : bus.divisor;
  assign q_fix = dz ? '1 : (neg_q ? -quo : quo);
  assign r_fix = neg_r ? -rem : rem;
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in(rem),
    .quo_in(quo),
    .dvsr(dvsr),
    .rem_out(rem_nx),
    .quo_out(quo_nx)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state: one RUN cycle per quotient bit, then sign fix-up, then result pulse
  always_comb
    state_nx = state == IDLE ? (accept ? RUN : IDLE) :
               state == RUN  ? (cnt == ITER_BITS'(1) ? FIX : RUN) :
               state == FIX  ? DONE : IDLE;
  // handshake outputs decoded from state
  always_comb begin
    bus.busy = state == RUN || state == FIX;
    bus.done = state == DONE;
  end
  // datapath: capture magnitudes, iterate, and publish sign-corrected results on entry to DONE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dvsr <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
      q_out <= '0;
      r_out <= '0;
      dz_out <= 1'b0;
    end else if (accept) begin
      cnt <= ITER_BITS'(WIDTH);
      rem <= '0;
      quo <= a_mag;
      dvsr <= b_mag;
      neg_q <= bus.is_signed && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
      neg_r <= bus.is_signed && bus.dividend[WIDTH-1];
      dz <= bus.divisor == '0;
    end else if (state == RUN) begin
      cnt <= cnt - ITER_BITS'(1);
      rem <= rem_nx;
      quo <= quo_nx;
    end else if (state == FIX) begin
      q_out <= q_fix;
      r_out <= r_fix;
      dz_out <= dz;
    end
  assign bus.quotient = q_out;
  assign bus.remainder = r_out;
  assign bus.div_by_zero = dz_out;
endmodule

// File: tb/tb_mips_divider.sv
// tb_mips_divider: directed table, corner sequences and random ops against an arithmetic model
module tb_mips_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  mips_divider_if #(.WIDTH(32)) bus ();
  mips_divider #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    string nm;
    logic s;
    logic [31:0] a, b, q, r;
    logic dz;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic dz);
    int sa, sb;
    sa = a;
    sb = b;
    dz = b == 0;
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = 0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  task automatic run_op(input string nm, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edz);
    int lat;
    logic busy_ok;
    lat = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.is_signed = s;
    bus.dividend = a;
    bus.divisor = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.is_signed = ~s;
    bus.dividend = $urandom;
    bus.divisor = $urandom;
    for (int n = 1; n <= 60; n++) begin
      if (n > 1) @(negedge clk);
      if (bus.done) begin
        lat = n;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
    end
    chk({nm, " latency"}, lat, 34);
    chk({nm, " busy while running"}, {31'b0, busy_ok}, 1);
    chk({nm, " busy at done"}, {31'b0, bus.busy}, 0);
    chk({nm, " quotient"}, bus.quotient, eq);
    chk({nm, " remainder"}, bus.remainder, er);
    chk({nm, " div_by_zero"}, {31'b0, bus.div_by_zero}, {31'b0, edz});
    @(negedge clk);
    chk({nm, " done single pulse"}, {31'b0, bus.done}, 0);
    chk({nm, " quotient hold"}, bus.quotient, eq);
  endtask

  initial begin
    vec_t tbl[$];
    logic [31:0] q, r, a, b;
    logic dz, s;
    int dones[$];
    int cnt_done;
    bus.start = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    tbl.push_back('{"u100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0});
    tbl.push_back('{"s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0});
    tbl.push_back('{"u-7/2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0});
    tbl.push_back('{"u5/0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1});
    tbl.push_back('{"s5/0", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1});
    tbl.push_back('{"s-5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1});
    tbl.push_back('{"smin/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0});
    tbl.push_back('{"s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0});
    tbl.push_back('{"umax/umax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0});
    tbl.push_back('{"s-1/-1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0});
    tbl.push_back('{"u0/5", 1'b0, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0});
    tbl.push_back('{"smin/smin", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0, 1'b0});
    tbl.push_back('{"umax/3", 1'b0, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 32'd0, 1'b0});
    #12;
    chk("reset busy", {31'b0, bus.busy}, 0);
    chk("reset done", {31'b0, bus.done}, 0);
    chk("reset quotient", bus.quotient, 0);
    chk("reset remainder", bus.remainder, 0);
    chk("reset div_by_zero", {31'b0, bus.div_by_zero}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (tbl[i]) run_op(tbl[i].nm, tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz);
    run_op("pre-reset 5/0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.is_signed = 1'b0;
    bus.dividend = 32'd1000;
    bus.divisor = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun reset busy", {31'b0, bus.busy}, 0);
    chk("midrun reset quotient", bus.quotient, 0);
    chk("midrun reset remainder", bus.remainder, 0);
    chk("midrun reset div_by_zero", {31'b0, bus.div_by_zero}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) cnt_done++;
    end
    chk("no done after reset", cnt_done, 0);
    run_op("post-reset 9/4", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.is_signed = 1'b0;
    bus.dividend = 32'd100;
    bus.divisor = 32'd7;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (n == 5) begin
        bus.dividend = 32'd9;
        bus.divisor = 32'd4;
      end
      if (bus.done) begin
        dones.push_back(n);
        if (dones.size() == 1) begin
          chk("held start q1", bus.quotient, 14);
          chk("held start r1", bus.remainder, 2);
        end else if (dones.size() == 2) begin
          chk("held start q2", bus.quotient, 2);
          chk("held start r2", bus.remainder, 1);
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    chk("held start done count", dones.size(), 2);
    chk("held start first done", dones.size() > 0 ? dones[0] : -1, 34);
    chk("held start second done", dones.size() > 1 ? dones[1] : -1, 69);
    repeat (40) @(negedge clk);
    for (int k = 0; k < 150; k++) begin
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: a = 32'h8000_0000;
        1: a = $urandom_range(0, 20);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: b = 0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 16);
        3: b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      model(s, a, b, q, r, dz);
      run_op($sformatf("rand%0d %s %h/%h", k, s ? "s" : "u", a, b), s, a, b, q, r, dz);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
